// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-credit vending controller with per-item stock, change/refund pulses and 7-seg credit display
module vend_ctrl #(
  parameter int unsigned N_ITEMS = 3,
  parameter logic [8*N_ITEMS-1:0] PRICES = {8'd3, 8'd2, 8'd1},
  parameter int unsigned STOCK_INIT = 4,
  parameter int unsigned MAX_CREDIT = 99,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m1,
  input  logic               m5,
  input  logic [N_ITEMS-1:0] sel,
  input  logic               cancel,
  input  logic               restock,
  output logic               vend,
  output logic [2:0]         vend_item,
  output logic               coin_out1,
  output logic               coin_out5,
  output logic               coin_reject,
  output logic               insufficient,
  output logic               sold_out,
  output logic [6:0]         credit,
  output logic [6:0]         seg_tens,
  output logic [6:0]         seg_ones
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;
  state_t state_q, state_d;
  logic [6:0] credit_q, credit_d, seg_tens_q, seg_tens_d, seg_ones_q, seg_ones_d;
  logic [3:0] stock_q [N_ITEMS];
  logic [3:0] stock_d [N_ITEMS];
  logic [TW-1:0] timer_q, timer_d;
  logic gap_q, gap_d, vend_q, vend_d, c1_q, c1_d, c5_q, c5_d;
  logic rej_q, rej_d, ins_q, ins_d, sold_q, sold_d;
  logic [2:0] item_q, item_d, idx;
  logic [7:0] price, sum;
  logic [3:0] stk;
  logic [2:0] add;
  logic open_st, do_cancel, any_sel, sell, accept, timeout, pulse, chg5;
  function automatic logic [6:0] seg7(input logic [6:0] d);
    case (d)
      7'd0: seg7 = 7'b0000001;
      7'd1: seg7 = 7'b1001111;
      7'd2: seg7 = 7'b0010010;
      7'd3: seg7 = 7'b0000110;
      7'd4: seg7 = 7'b1001100;
      7'd5: seg7 = 7'b0100100;
      7'd6: seg7 = 7'b0100000;
      7'd7: seg7 = 7'b0001111;
      7'd8: seg7 = 7'b0000000;
      7'd9: seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
  // lowest-index select wins; descending scan lets the lowest set bit overwrite
  always_comb begin
    idx = 3'd0;
    price = 8'd0;
    stk = 4'd0;
    for (int i = N_ITEMS - 1; i >= 0; i--)
      if (sel[i]) begin
        idx = 3'(i);
        price = PRICES[8*i +: 8];
        stk = stock_q[i];
      end
  end
  assign open_st   = state_q == IDLE || state_q == ACCUM;
  assign do_cancel = state_q == ACCUM && cancel;
  assign any_sel   = open_st && !do_cancel && |sel;
  assign sell      = any_sel && stk != 4'd0 && {1'b0, credit_q} >= price;
  assign add       = (m5 ? 3'd5 : 3'd0) + {2'b0, m1};
  assign sum       = {1'b0, credit_q} + {5'b0, add};
  assign accept    = (m1 || m5) && open_st && !do_cancel && !any_sel && sum <= 8'(MAX_CREDIT);
  assign timeout   = state_q == ACCUM && !accept && !any_sel && timer_q == TW'(TIMEOUT - 1);
  assign pulse     = credit_q != 7'd0 && (state_q == VEND || (state_q == CHANGE && !gap_q));
  assign chg5      = credit_q >= 7'd5;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      credit_q <= 7'd0;
      timer_q <= '0;
      gap_q <= 1'b0;
      vend_q <= 1'b0;
      item_q <= 3'd0;
      c1_q <= 1'b0;
      c5_q <= 1'b0;
      rej_q <= 1'b0;
      ins_q <= 1'b0;
      sold_q <= 1'b0;
      seg_tens_q <= 7'b0000001;
      seg_ones_q <= 7'b0000001;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= 4'(STOCK_INIT);
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      timer_q <= timer_d;
      gap_q <= gap_d;
      vend_q <= vend_d;
      item_q <= item_d;
      c1_q <= c1_d;
      c5_q <= c5_d;
      rej_q <= rej_d;
      ins_q <= ins_d;
      sold_q <= sold_d;
      seg_tens_q <= seg_tens_d;
      seg_ones_q <= seg_ones_d;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = sell ? VEND : accept ? ACCUM : IDLE;
      ACCUM:   state_d = (do_cancel || timeout) ? CHANGE : sell ? VEND : ACCUM;
      VEND:    state_d = credit_q != 7'd0 ? CHANGE : IDLE;
      default: state_d = (!gap_q && credit_q == 7'd0) ? IDLE : CHANGE;
    endcase
  end
  // the first change pulse leaves straight from VEND; gap_q forces a quiet cycle after each pulse
  always_comb begin
    credit_d = sell ? credit_q - price[6:0] : accept ? sum[6:0] :
               pulse ? credit_q - (chg5 ? 7'd5 : 7'd1) : credit_q;
    timer_d = (state_q == ACCUM && !accept && !any_sel && !timeout) ? timer_q + 1'b1 : '0;
    gap_d = pulse;
    c5_d = pulse && chg5;
    c1_d = pulse && !chg5;
    vend_d = sell;
    item_d = sell ? idx : item_q;
    rej_d = (m1 || m5) && !accept;
    ins_d = any_sel && stk != 4'd0 && !sell;
    sold_d = any_sel && stk == 4'd0;
    for (int i = 0; i < N_ITEMS; i++)
      stock_d[i] = restock ? 4'(STOCK_INIT) : (sell && idx == 3'(i)) ? stock_q[i] - 4'd1 : stock_q[i];
    seg_tens_d = seg7(credit_d / 7'd10);
    seg_ones_d = seg7(credit_d % 7'd10);
  end
  assign vend = vend_q;
  assign vend_item = item_q;
  assign coin_out1 = c1_q;
  assign coin_out5 = c5_q;
  assign coin_reject = rej_q;
  assign insufficient = ins_q;
  assign sold_out = sold_q;
  assign credit = credit_q;
  assign seg_tens = seg_tens_q;
  assign seg_ones = seg_ones_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed stimulus with a queue scoreboard of expected output pulses
module tb_vend_ctrl;
  logic clk = 1'b0, rst = 1'b0, m1 = 1'b0, m5 = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic [2:0] sel = 3'b000;
  logic vend, coin_out1, coin_out5, coin_reject, insufficient, sold_out;
  logic [2:0] vend_item;
  logic [6:0] credit, seg_tens, seg_ones;
  int n_cmp = 0, n_fail = 0;
  logic [15:0] sb[$];
  logic prev_coin = 1'b0;
  vend_ctrl dut (
    .clk(clk), .rst(rst), .m1(m1), .m5(m5), .sel(sel), .cancel(cancel), .restock(restock),
    .vend(vend), .vend_item(vend_item), .coin_out1(coin_out1), .coin_out5(coin_out5),
    .coin_reject(coin_reject), .insufficient(insufficient), .sold_out(sold_out),
    .credit(credit), .seg_tens(seg_tens), .seg_ones(seg_ones)
  );
  always #5 clk = ~clk;
  // event word: {vend, coin1, coin5, reject, insufficient, sold_out, item, credit after event}
  function automatic logic [15:0] mk(logic [5:0] k, logic [2:0] it, logic [6:0] cr);
    return {k, it, cr};
  endfunction
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(logic a1, logic a5, logic [2:0] s, logic c, logic r);
    m1 = a1; m5 = a5; sel = s; cancel = c; restock = r;
    @(posedge clk); #1;
    m1 = 0; m5 = 0; sel = 0; cancel = 0; restock = 0;
  endtask
  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic drain(int lim);
    int k = 0;
    while (sb.size() != 0 && k < lim) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d events outstanding expected 0", sb.size());
      sb.delete();
    end
    idle(3);
  endtask
  task automatic exp_ev(logic [5:0] k, logic [2:0] it, logic [6:0] cr);
    sb.push_back(mk(k, it, cr));
  endtask
  initial forever begin
    @(negedge clk);
    if (rst && (vend || coin_out1 || coin_out5 || coin_reject || insufficient || sold_out)) begin
      if (coin_out1 || coin_out5) check("pulse_gap", {15'd0, prev_coin}, 16'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: got %h expected none",
                 mk({vend, coin_out1, coin_out5, coin_reject, insufficient, sold_out}, vend ? vend_item : 3'd0, credit));
      end else
        check("event", mk({vend, coin_out1, coin_out5, coin_reject, insufficient, sold_out},
                          vend ? vend_item : 3'd0, credit), sb.pop_front());
    end
    prev_coin = rst && (coin_out1 || coin_out5);
  end
  initial begin
    idle(2);
    check("rst_credit", {9'd0, credit}, 16'd0);
    check("rst_seg", {2'd0, seg_tens, seg_ones}, {2'd0, 7'b0000001, 7'b0000001});
    check("rst_pulses", {10'd0, vend, coin_out1, coin_out5, coin_reject, insufficient, sold_out}, 16'd0);
    rst = 1'b1;
    idle(1);
    step(0, 1, 3'b000, 0, 0);
    check("m5_credit", {9'd0, credit}, 16'd5);
    check("m5_seg_ones", {9'd0, seg_ones}, {9'd0, 7'b0100100});
    exp_ev(6'b100000, 3'd0, 7'd4);
    for (int c = 3; c >= 0; c--) exp_ev(6'b010000, 3'd0, 7'(c));
    step(0, 0, 3'b001, 0, 0);
    check("vend_credit", {9'd0, credit}, 16'd4);
    drain(40);
    step(1, 0, 3'b000, 0, 0);
    exp_ev(6'b000010, 3'd0, 7'd1);
    step(0, 0, 3'b010, 0, 0);
    step(0, 1, 3'b000, 0, 0);
    check("credit6", {9'd0, credit}, 16'd6);
    exp_ev(6'b100000, 3'd1, 7'd4);
    for (int c = 3; c >= 0; c--) exp_ev(6'b010000, 3'd0, 7'(c));
    step(0, 0, 3'b010, 0, 0);
    drain(40);
    repeat (19) step(0, 1, 3'b000, 0, 0);
    repeat (2) step(1, 0, 3'b000, 0, 0);
    check("credit97", {9'd0, credit}, 16'd97);
    check("seg97", {2'd0, seg_tens, seg_ones}, {2'd0, 7'b0000100, 7'b0001111});
    exp_ev(6'b000100, 3'd0, 7'd97);
    step(0, 1, 3'b000, 0, 0);
    check("reject_credit", {9'd0, credit}, 16'd97);
    for (int c = 92; c >= 2; c -= 5) exp_ev(6'b001000, 3'd0, 7'(c));
    exp_ev(6'b010000, 3'd0, 7'd1);
    exp_ev(6'b010000, 3'd0, 7'd0);
    step(0, 0, 3'b000, 1, 0);
    drain(100);
    step(1, 1, 3'b000, 0, 0);
    check("both_coins", {9'd0, credit}, 16'd6);
    check("seg6", {2'd0, seg_tens, seg_ones}, {2'd0, 7'b0000001, 7'b0100000});
    exp_ev(6'b001000, 3'd0, 7'd1);
    exp_ev(6'b010000, 3'd0, 7'd0);
    step(0, 0, 3'b000, 1, 0);
    drain(40);
    for (int n = 0; n < 4; n++) begin
      repeat (3) step(1, 0, 3'b000, 0, 0);
      exp_ev(6'b100000, 3'd2, 7'd0);
      step(0, 0, 3'b100, 0, 0);
      drain(20);
    end
    repeat (3) step(1, 0, 3'b000, 0, 0);
    exp_ev(6'b000001, 3'd0, 7'd3);
    step(0, 0, 3'b100, 0, 0);
    step(0, 0, 3'b000, 0, 1);
    exp_ev(6'b100000, 3'd2, 7'd0);
    step(0, 0, 3'b100, 0, 0);
    drain(20);
    step(0, 1, 3'b000, 0, 0);
    step(0, 1, 3'b000, 0, 0);
    step(1, 0, 3'b000, 0, 0);
    check("credit11", {9'd0, credit}, 16'd11);
    exp_ev(6'b001000, 3'd0, 7'd6);
    exp_ev(6'b001000, 3'd0, 7'd1);
    exp_ev(6'b010000, 3'd0, 7'd0);
    step(0, 0, 3'b001, 1, 0);
    drain(40);
    repeat (3) step(1, 0, 3'b000, 0, 0);
    for (int c = 2; c >= 0; c--) exp_ev(6'b010000, 3'd0, 7'(c));
    idle(990);
    check("no_early_refund", {9'd0, credit}, 16'd3);
    drain(100);
    step(0, 1, 3'b000, 0, 0);
    step(1, 0, 3'b000, 0, 0);
    step(1, 0, 3'b000, 0, 0);
    step(0, 0, 3'b000, 1, 0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    check("rst_mid_credit", {9'd0, credit}, 16'd0);
    check("rst_mid_seg", {2'd0, seg_tens, seg_ones}, {2'd0, 7'b0000001, 7'b0000001});
    idle(20);
    check("rst_mid_quiet", {9'd0, credit}, 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised vending-machine controller: accumulates coin credit, sells one of `N_ITEMS` products at per-item prices, tracks per-item stock, and returns change or refunds as coin pulses. It drives a two-digit seven-segment credit display with active-low segments. It sits between the debounced front-panel inputs (coins, item buttons, cancel) and the dispenser/coin-hopper drivers.

## Interface
- `N_ITEMS`, 3: number of products, 1..8.
- `PRICES`, {8'd3,8'd2,8'd1}: packed prices; item i price = `PRICES[8i+7:8i]`, each 1..99.
- `STOCK_INIT`, 4: units loaded per item at reset/restock, 1..15.
- `MAX_CREDIT`, 99: credit ceiling, ≤99.
- `TIMEOUT`, 1000: idle cycles in ACCUM before automatic refund, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `m1`  in  1  one-unit coin pulse, single cycle, synchronised upstream.
- `m5`  in  1  five-unit coin pulse.
- `sel`  in  N_ITEMS  item-select pulses.
- `cancel`  in  1  refund request pulse.
- `restock`  in  1  reload all stock counters to `STOCK_INIT`.
- `vend`  out  1  one-cycle dispense strobe.
- `vend_item`  out  3  index of dispensed item, valid with `vend`.
- `coin_out1`, `coin_out5`  out  1 each  one-cycle change/refund coin pulses.
- `coin_reject`  out  1  one-cycle pulse: inserted coin not accepted.
- `insufficient`  out  1  one-cycle pulse: select with credit < price.
- `sold_out`  out  1  one-cycle pulse: select of item with zero stock.
- `credit`  out  7  current credit, binary.
- `seg_tens`, `seg_ones`  out  7 each  credit digits; bit6=a … bit0=g, active-low (0 = 7'b0000001, 1 = 7'b1001111).

## Operation
- States: IDLE (credit 0), ACCUM, VEND, CHANGE.
- Coins accepted only in IDLE/ACCUM. Added value = m1 + 5·m5 (both in same cycle → +6). If credit + added > `MAX_CREDIT`, whole insertion rejected: `coin_reject`, credit unchanged. Coins in VEND/CHANGE: rejected.
- Accepted coin in IDLE → ACCUM. Any accepted coin or select restarts timeout counter.
- Select in IDLE/ACCUM: multiple bits set → lowest index wins. Priority: `cancel` > select > coins; coins in a cycle with cancel or a winning select are rejected.
- Select with stock 0 → `sold_out`; with credit < price → `insufficient`; both stay in current state. Otherwise → VEND.
- VEND (one cycle): `vend`=1, `vend_item`=index, credit -= price, stock[index] -= 1. Next: CHANGE if remaining credit > 0, else IDLE.
- CHANGE: while credit ≥5 emit `coin_out5` and subtract 5, then `coin_out1` and subtract 1; one pulse every other cycle (pulse, gap, pulse…). Credit 0 → IDLE.
- `cancel` in ACCUM, or timeout counter reaching `TIMEOUT`, → CHANGE (full refund). `cancel` in IDLE/VEND/CHANGE ignored.
- `restock` reloads all counters in any state; coincident with VEND, reload wins.
- Display: credit/10 and credit%10 decoded; tens digit shows 0 when blank.

## Timing
- Reset: state IDLE, credit 0, stock all `STOCK_INIT`, timer 0, all pulse outputs 0, `vend_item` 0, segments both 7'b0000001.
- All outputs registered. Coin at edge t → `credit` updated after edge t (visible cycle t+1); `coin_reject` in cycle t+1.
- Select at t → `vend` in cycle t+1; first change pulse cycle t+2; k coins of change finish by cycle t+2k; IDLE the cycle after last pulse's gap.
- Reset asserted mid-VEND/CHANGE: pending change discarded, all state to reset values on that edge.
- Timeout: N cycles of no activity in ACCUM, refund starts after edge N=`TIMEOUT`.

## Test plan
- Reset, m5 then sel=001 → credit 5, `vend` item 0, credit 4, four `coin_out1` pulses on alternate cycles, credit 0, IDLE.
- m1, sel=010 → `insufficient`, credit stays 1; m5 → credit 6; sel=010 → vend item 1, one `coin_out1`... credit 4→ four `coin_out1`.
- Credit 97, m5 → `coin_reject`, credit 97; m1 and m5 same cycle at credit 0 → credit 6.
- Sell item 2 four times (STOCK_INIT=4), fifth select → `sold_out`; `restock` → sale succeeds.
- Credit 11, `cancel` with sel=001 same cycle → refund: two `coin_out5`, one `coin_out1`, no vend; credit 3 idle `TIMEOUT` cycles → three `coin_out1`.
- Reset asserted during CHANGE with credit 7 → no further coin pulses, segments 7'b0000001.
